// File: rtl/msc_pkg.sv
// msc_pkg: shared FSM state, edge-mode encodings and qualification counter width
package msc_pkg;

    typedef enum logic [1:0] {IDLE, QUAL, CAPTURE, WAIT_LOW} state_e;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    localparam int CNT_W = 4;

endpackage

// File: rtl/multi_sync_capture_if.sv
// msc_if: source-facing bundle of multi_sync_capture; rej_cnt exists only with MSC_REJECT_CNT_EN
interface msc_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8
);
    logic              ena;
    logic [N_CH-1:0]   async_in;
    logic [1:0]        edge_mode;
    logic [N_CH-1:0]   lvl_out;
    logic [N_CH-1:0]   evt_out;
    logic              stb_async;
    logic [DATA_W-1:0] data_async;
    logic [DATA_W-1:0] data_out;
    logic              data_vld;
    logic              ack_out;
    logic              busy;
`ifdef MSC_REJECT_CNT_EN
    logic [7:0]        rej_cnt;
`endif

    modport slave (
        input  ena, async_in, edge_mode, stb_async, data_async,
`ifdef MSC_REJECT_CNT_EN
        output rej_cnt,
`endif
        output lvl_out, evt_out, data_out, data_vld, ack_out, busy
    );

    modport master (
        output ena, async_in, edge_mode, stb_async, data_async,
`ifdef MSC_REJECT_CNT_EN
        input  rej_cnt,
`endif
        input  lvl_out, evt_out, data_out, data_vld, ack_out, busy
    );

endinterface

// File: rtl/sync_chain.sv
// sync_chain: WIDTH-bit multi-flop synchronizer, STAGES deep (STAGES >= 2)
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;

    always_comb stage_d = {stage_q[STAGES-2:0], d};

    always_ff @(posedge clk) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/multi_sync_capture.sv
// multi_sync_capture: synchronized level/edge channels plus debounced bundled-data capture with 4-phase ack.
// Define MSC_REJECT_CNT_EN to add the saturating rejected-strobe counter rej_cnt.
module multi_sync_capture
    import msc_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int STAGES     = 2,
    parameter int DATA_W     = 8,
    parameter int STABLE_CYC = 2
) (
    input logic  clk,
    input logic  rst,
    msc_if.slave bus
);

    logic [N_CH-1:0]   lvl, prev_q, prev_d, evt_q, evt_d;
    logic              stb_s, rise_en, fall_en;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d, ack_q, ack_d;

    sync_chain #(.WIDTH(N_CH), .STAGES(STAGES)) u_ch_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.async_in),
        .q   (lvl)
    );

    sync_chain #(.WIDTH(1), .STAGES(STAGES)) u_stb_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.stb_async),
        .q   (stb_s)
    );

    always_comb begin
        rise_en = bus.edge_mode == EDGE_RISE || bus.edge_mode == EDGE_BOTH;
        fall_en = bus.edge_mode == EDGE_FALL || bus.edge_mode == EDGE_BOTH;
        prev_d  = lvl;
        evt_d   = (bus.ena && bus.edge_mode != EDGE_NONE)
                ? ((lvl & ~prev_q & {N_CH{rise_en}}) | (~lvl & prev_q & {N_CH{fall_en}}))
                : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            evt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            evt_q  <= evt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ack_q   <= ack_d;
        end
    end

    // strobe must stay high STABLE_CYC qualified cycles; losing it or ena aborts qualification
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (stb_s && bus.ena) begin
                    state_d = QUAL;
                    cnt_d   = CNT_W'(1);
                end
            end
            QUAL: begin
                if (!stb_s || !bus.ena)                 state_d = IDLE;
                else if (cnt_q == CNT_W'(STABLE_CYC))   state_d = CAPTURE;
                else                                    cnt_d   = cnt_q + CNT_W'(1);
            end
            CAPTURE:  state_d = WAIT_LOW;
            WAIT_LOW: state_d = stb_s ? WAIT_LOW : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d = (state_q == CAPTURE) ? bus.data_async : data_q;
        vld_d  = state_q == CAPTURE;
        ack_d  = (state_q == CAPTURE) ? 1'b1 : (state_q == WAIT_LOW && !stb_s) ? 1'b0 : ack_q;
    end

`ifdef MSC_REJECT_CNT_EN
    logic [7:0] rej_q, rej_d;

    always_comb rej_d = (state_q == QUAL && (!stb_s || !bus.ena) && rej_q != 8'hFF) ? rej_q + 8'd1 : rej_q;

    always_ff @(posedge clk) begin
        if (rst) rej_q <= '0;
        else     rej_q <= rej_d;
    end

    assign bus.rej_cnt = rej_q;
`endif

    assign bus.lvl_out  = lvl;
    assign bus.evt_out  = evt_q;
    assign bus.data_out = data_q;
    assign bus.data_vld = vld_q;
    assign bus.ack_out  = ack_q;
    assign bus.busy     = state_q != IDLE;

endmodule

// File: tb/tb_multi_sync_capture.sv
// tb_multi_sync_capture: directed table-driven bench for multi_sync_capture (STAGES=2, STABLE_CYC=2)
module tb_multi_sync_capture;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    msc_if #(.N_CH(4), .DATA_W(8)) bus ();

    multi_sync_capture #(.N_CH(4), .STAGES(2), .DATA_W(8), .STABLE_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic       ena;
        logic [3:0] ain;
        logic [1:0] em;
        logic [3:0] lvl;
        logic [3:0] evt;
    } vec_t;

    vec_t tv[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_vld(input int lim, output int lat);
        lat = -1;
        for (int i = 1; i <= lim; i++) begin
            step();
            if (bus.data_vld) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic wait_idle(input int lim);
        int ok = 0;
        for (int i = 0; i < lim && !ok; i++) begin
            step();
            if (!bus.busy) ok = 1;
        end
        chk("idle_reached", 32'(ok), 32'd1);
        chk("ack_low_idle", 32'(bus.ack_out), 32'd0);
    endtask

    initial begin
        int lat, vld_seen, busy_seen;
        rst            = 1'b1;
        bus.ena        = 1'b1;
        bus.async_in   = 4'hF;
        bus.edge_mode  = 2'b00;
        bus.stb_async  = 1'b0;
        bus.data_async = 8'h00;

        //        rst   ena   ain    em     lvl    evt
        tv.push_back('{1'b1, 1'b1, 4'hF, 2'd0, 4'h0, 4'h0});
        tv.push_back('{1'b1, 1'b1, 4'hF, 2'd0, 4'h0, 4'h0});
        tv.push_back('{1'b1, 1'b1, 4'hF, 2'd0, 4'h0, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd0, 4'h0, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd0, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd0, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hE, 2'd1, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hE, 2'd1, 4'hE, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hE, 2'd1, 4'hE, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd1, 4'hE, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd1, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd1, 4'hF, 4'h1});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd1, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hE, 2'd3, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hE, 2'd3, 4'hE, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hE, 2'd3, 4'hE, 4'h1});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd3, 4'hE, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd3, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd3, 4'hF, 4'h1});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd3, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b0, 4'hE, 2'd3, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b0, 4'hE, 2'd3, 4'hE, 4'h0});
        tv.push_back('{1'b0, 1'b0, 4'hE, 2'd3, 4'hE, 4'h0});
        tv.push_back('{1'b0, 1'b0, 4'hF, 2'd3, 4'hE, 4'h0});
        tv.push_back('{1'b0, 1'b0, 4'hF, 2'd3, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b0, 4'hF, 2'd3, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd3, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'h7, 2'd2, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'h7, 2'd2, 4'h7, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'h7, 2'd2, 4'h7, 4'h8});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd2, 4'h7, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd2, 4'hF, 4'h0});
        tv.push_back('{1'b0, 1'b1, 4'hF, 2'd2, 4'hF, 4'h0});

        foreach (tv[i]) begin
            rst           = tv[i].rst;
            bus.ena       = tv[i].ena;
            bus.async_in  = tv[i].ain;
            bus.edge_mode = tv[i].em;
            step();
            n_vec++;
            if ({bus.lvl_out, bus.evt_out, bus.data_out, bus.data_vld, bus.ack_out, bus.busy} !==
                {tv[i].lvl, tv[i].evt, 8'h00, 1'b0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL vec%0d: lvl=%h evt=%h data=%h vld=%b ack=%b busy=%b expected lvl=%h evt=%h others 0",
                         i, bus.lvl_out, bus.evt_out, bus.data_out, bus.data_vld, bus.ack_out, bus.busy,
                         tv[i].lvl, tv[i].evt);
            end
        end

`ifdef MSC_REJECT_CNT_EN
        chk("rej_reset", 32'(bus.rej_cnt), 32'd0);
`endif

        // capture: strobe high 10 cycles, capture visible after edge 6, ack drops 2 edges after strobe-synced low
        bus.data_async = 8'hAB;
        bus.stb_async  = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            if (k == 11) bus.stb_async = 1'b0;
            step();
            chk($sformatf("cap_k%0d", k),
                {24'h0, bus.data_out, bus.data_vld, bus.ack_out, bus.busy},
                {24'h0, (k >= 6) ? 8'hAB : 8'h00, 1'(k == 6), 1'(k >= 6 && k <= 12), 1'(k >= 3 && k <= 12)});
        end

        // glitch: one-cycle strobe is rejected during qualification
        bus.data_async = 8'h55;
        bus.stb_async  = 1'b1;
        step();
        bus.stb_async  = 1'b0;
        step();
        step();
        chk("glitch_qual_busy", 32'(bus.busy), 32'd1);
        step();
        chk("glitch_rej_busy", 32'(bus.busy), 32'd0);
        vld_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            vld_seen += int'(bus.data_vld);
        end
        chk("glitch_no_vld", 32'(vld_seen), 32'd0);
        chk("glitch_data_hold", 32'(bus.data_out), 32'hAB);
`ifdef MSC_REJECT_CNT_EN
        chk("rej_one", 32'(bus.rej_cnt), 32'd1);
`endif
        vld_seen = 0;
        for (int g = 0; g < 300; g++) begin
            bus.stb_async = 1'b1;
            step();
            vld_seen += int'(bus.data_vld);
            step();
            vld_seen += int'(bus.data_vld);
            bus.stb_async = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step();
                vld_seen += int'(bus.data_vld);
            end
        end
        chk("glitch300_no_vld", 32'(vld_seen), 32'd0);
        chk("glitch300_data", 32'(bus.data_out), 32'hAB);
`ifdef MSC_REJECT_CNT_EN
        chk("rej_sat", 32'(bus.rej_cnt), 32'd255);
`endif

        // enable gating: strobe high but ena low never leaves IDLE
        bus.ena        = 1'b0;
        bus.data_async = 8'hDA;
        bus.stb_async  = 1'b1;
        vld_seen  = 0;
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            vld_seen  += int'(bus.data_vld);
            busy_seen += int'(bus.busy);
        end
        chk("ena0_no_vld", 32'(vld_seen), 32'd0);
        chk("ena0_no_busy", 32'(busy_seen), 32'd0);
        bus.ena = 1'b1;
        wait_vld(10, lat);
        chk("ena1_latency", 32'(lat), 32'd4);
        chk("ena1_data", 32'(bus.data_out), 32'hDA);
        step();
        chk("vld_single", 32'(bus.data_vld), 32'd0);
        bus.stb_async = 1'b0;
        wait_idle(10);

        // reset during WAIT_LOW with strobe still high
        bus.data_async = 8'h3C;
        bus.stb_async  = 1'b1;
        wait_vld(12, lat);
        chk("rst_pre_latency", 32'(lat), 32'd6);
        chk("rst_pre_data", 32'(bus.data_out), 32'h3C);
        step();
        step();
        chk("rst_pre_ack_busy", {30'h0, bus.ack_out, bus.busy}, 32'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_outs", {22'h0, bus.data_out, bus.data_vld, bus.ack_out}, 32'h0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        bus.data_async = 8'hC3;
        wait_vld(12, lat);
        chk("rst_post_latency", 32'(lat), 32'd6);
        chk("rst_post_data", 32'(bus.data_out), 32'hC3);
        bus.stb_async = 1'b0;
        wait_idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_sync_capture.md
Name: multi_sync_capture

Overview:
Destination-clock receiver for asynchronous inputs: N_CH single-bit channels pass through parametrised-depth synchronizers with selectable edge detection. A bundled-data DATA_W bus is captured under a synchronized, debounced strobe with a 4-phase ack back to the source. Successor to the fixed 2-FF / strobe / pulse synchronizer modes, generalised in channel count, depth and qualification time.

Parameters:
N_CH, 4, number of single-bit level channels
STAGES, 2, synchronizer flop depth (legal >= 2)
DATA_W, 8, captured bus width
STABLE_CYC, 2, cycles the synchronized strobe must stay high before capture (legal 1..15)

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
ena  in  1  block enable
async_in  in  N_CH  asynchronous level inputs
edge_mode  in  2  00 none, 01 rise, 10 fall, 11 both
lvl_out  out  N_CH  synchronized levels
evt_out  out  N_CH  one-cycle edge events
stb_async  in  1  asynchronous capture strobe (source holds data stable while high)
data_async  in  DATA_W  bundled data bus
data_out  out  DATA_W  captured data
data_vld  out  1  one-cycle pulse on capture
ack_out  out  1  4-phase acknowledge level to source
busy  out  1  high whenever FSM not IDLE

Behaviour:
- Reset (rst=1 at clk edge): all synchronizer flops, lvl_out, evt_out, data_out, data_vld, ack_out, busy = 0; FSM -> IDLE; counter = 0. Applies mid-operation; ack_out drops the cycle after reset is sampled.
- Channels: lvl_out = last flop of STAGES-deep chain; latency STAGES cycles from first sampling edge. A prev register holds the previous lvl_out. evt_out[i] is registered, asserted one cycle after lvl_out[i] changes (latency STAGES+1), for one cycle, filtered by edge_mode. edge_mode changes take effect next cycle.
- ena=0: chains keep shifting, lvl_out keeps tracking, evt_out forced 0.
- Strobe: stb_async synchronized through its own STAGES chain -> stb_s.
- FSM:
  - IDLE: stb_s=1 and ena=1 -> QUAL, cnt=1.
  - QUAL: stb_s=0 or ena=0 -> IDLE (rejected); cnt==STABLE_CYC -> CAPTURE; else cnt++.
  - CAPTURE (1 cycle): data_out <= data_async; data_vld=1; ack_out <= 1; -> WAIT_LOW.
  - WAIT_LOW: stays until stb_s=0, then ack_out <= 0, -> IDLE. ena is ignored here; the handshake always completes.
- data_out holds its value between captures. data_vld is never high two consecutive cycles.
- Strobe high at reset release: a normal qualified capture follows. This is intended.
- busy = (state != IDLE), registered with the state.

Optional Feature:
MSC_REJECT_CNT_EN
- Defined: adds output rej_cnt[7:0]. It increments on every QUAL->IDLE rejection, saturates at 255 and clears on rst.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package msc_pkg: FSM state enum (IDLE, QUAL, CAPTURE, WAIT_LOW), edge_mode constants (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH), counter width constant (4 bits).
- One sub-module sync_chain, parametrised by WIDTH and STAGES. Instantiated twice: N_CH-wide for async_in, 1-wide for stb_async.

Test Plan:
(All with STAGES=2, STABLE_CYC=2.)
1. Reset: rst=1 for 3 cycles with async_in=4'hF -> all outputs 0 during reset. After release, lvl_out=4'hF at cycle 2 and no evt with edge_mode=00.
2. Edge detection: edge_mode=01, async_in[0] 0->1 -> lvl_out[0] high after 2 cycles, evt_out[0] single pulse at cycle 3. Falling edge -> no evt. edge_mode=11 -> pulse on both edges. ena=0 -> no evt while lvl_out still tracks.
3. Capture: data_async=8'hAB, stb_async high 10 cycles -> exactly one data_vld pulse about 5 cycles after rise, data_out=8'hAB, ack_out high from capture until 2-3 cycles after stb falls, busy high throughout.
4. Glitch: 1-cycle stb_async pulse with data_async=8'h55 -> no data_vld, data_out stays 8'hAB. With MSC_REJECT_CNT_EN, rej_cnt 0->1; 300 glitches -> rej_cnt=255.
5. Enable gating: ena=0 while stb_async high -> no capture. ena returns to 1 with strobe still high -> one capture (8'hDA).
6. Reset mid-handshake: rst in WAIT_LOW -> ack_out=0, busy=0 next cycle. Strobe still high after release -> new capture with a fresh data_vld pulse.
